// File: rtl/opcode_issue_buffer_if.sv
// Fetch/decode handshake bundle for opcode_issue_buffer.
// The buffer uses the slave modport. The fetch and decode stages drive it through the master modport.
interface opcode_issue_buffer_if #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int OPW   = 7
);
    logic                       in_valid;
    logic                       in_ready;
    logic [IW-1:0]              in_instr;
    logic                       flush;
    logic                       dec_valid;
    logic                       dec_ready;
    logic [OPW-1:0]             dec_op;
    logic [IW-1:0]              dec_instr;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output in_valid, in_instr, flush, dec_ready,
        input  in_ready, dec_valid, dec_op, dec_instr, count
    );

    modport slave (
        input  in_valid, in_instr, flush, dec_ready,
        output in_ready, dec_valid, dec_op, dec_instr, count
    );
endinterface

// File: rtl/opcode_issue_buffer.sv
// Circular instruction FIFO that feeds the head opcode to the control decoder.
// An empty or flushing buffer presents NOP_OP on the decoder inputs.
module opcode_issue_buffer #(
    parameter int              DEPTH  = 4,
    parameter int              IW     = 32,
    parameter int              OPW    = 7,
    parameter logic [OPW-1:0]  NOP_OP = 7'h13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    opcode_issue_buffer_if.slave bus
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          dec_valid;
    logic          in_ready;
    logic [IW-1:0] head;

    // Flush suppresses both sides, so a pop during a flush cycle is ignored.
    assign in_ready  = rst_n & ~bus.flush & (count != FULL_CNT);
    assign dec_valid = (count != '0) & ~bus.flush;
    assign push      = bus.in_valid & in_ready;
    assign pop       = dec_valid & bus.dec_ready;
    assign head      = mem[rd_ptr];

    assign bus.in_ready  = in_ready;
    assign bus.dec_valid = dec_valid;
    assign bus.dec_op    = dec_valid ? head[OPW-1:0] : NOP_OP;
    assign bus.dec_instr = dec_valid ? head : '0;
    assign bus.count     = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_opcode_issue_buffer.sv
// Directed table-driven bench for opcode_issue_buffer, plus hand-written streaming and reset sequences.
module tb_opcode_issue_buffer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    opcode_issue_buffer_if #(.DEPTH(4), .IW(32), .OPW(7)) bus ();

    opcode_issue_buffer #(.DEPTH(4), .IW(32), .OPW(7), .NOP_OP(7'h13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic        fl;
        logic        dr;
        logic        e_dv;
        logic [6:0]  e_op;
        logic [31:0] e_instr;
        logic        e_ir;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input logic iv, input logic [31:0] instr, input logic fl,
                                input logic dr, input logic e_dv, input logic [6:0] e_op,
                                input logic [31:0] e_instr, input logic e_ir, input logic [2:0] e_cnt);
        vec_t v;
        v.iv = iv; v.instr = instr; v.fl = fl; v.dr = dr;
        v.e_dv = e_dv; v.e_op = e_op; v.e_instr = e_instr; v.e_ir = e_ir; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_dv, input logic [6:0] e_op,
                           input logic [31:0] e_instr, input logic e_ir, input logic [2:0] e_cnt);
        chk({tag, ".dec_valid"}, 32'(bus.dec_valid), 32'(e_dv));
        chk({tag, ".dec_op"},    32'(bus.dec_op),    32'(e_op));
        chk({tag, ".dec_instr"}, bus.dec_instr,      e_instr);
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(e_ir));
        chk({tag, ".count"},     32'(bus.count),     32'(e_cnt));
    endtask

    task automatic drive(input logic iv, input logic [31:0] instr, input logic fl, input logic dr);
        bus.in_valid  = iv;
        bus.in_instr  = instr;
        bus.flush     = fl;
        bus.dec_ready = dr;
    endtask

    function automatic logic [31:0] stream_instr(input int i);
        return {25'(i + 3), 7'(7'h40 + 7'(i))};
    endfunction

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // Idle, push 0x33 and stall, fill to full with wrap, drain
        tbl[0]  = mk(0, 32'h0,        0, 0, 0, 7'h13, 32'h0,        1, 0);
        tbl[1]  = mk(1, 32'h00000033, 0, 0, 0, 7'h13, 32'h0,        1, 0);
        tbl[2]  = mk(0, 32'h0,        0, 0, 1, 7'h33, 32'h00000033, 1, 1);
        tbl[3]  = mk(0, 32'h0,        0, 0, 1, 7'h33, 32'h00000033, 1, 1);
        tbl[4]  = mk(0, 32'h0,        0, 0, 1, 7'h33, 32'h00000033, 1, 1);
        tbl[5]  = mk(0, 32'h0,        0, 0, 1, 7'h33, 32'h00000033, 1, 1);
        tbl[6]  = mk(0, 32'h0,        0, 0, 1, 7'h33, 32'h00000033, 1, 1);
        tbl[7]  = mk(0, 32'h0,        0, 1, 1, 7'h33, 32'h00000033, 1, 1);
        tbl[8]  = mk(1, 32'h00A00003, 0, 0, 0, 7'h13, 32'h0,        1, 0);
        tbl[9]  = mk(1, 32'h00102023, 0, 0, 1, 7'h03, 32'h00A00003, 1, 1);
        tbl[10] = mk(1, 32'hFE000E63, 0, 0, 1, 7'h03, 32'h00A00003, 1, 2);
        tbl[11] = mk(1, 32'h0040006F, 0, 0, 1, 7'h03, 32'h00A00003, 1, 3);
        tbl[12] = mk(1, 32'h00008067, 0, 0, 1, 7'h03, 32'h00A00003, 0, 4);
        tbl[13] = mk(1, 32'h00008067, 0, 1, 1, 7'h03, 32'h00A00003, 0, 4);
        tbl[14] = mk(1, 32'h00008067, 0, 1, 1, 7'h23, 32'h00102023, 1, 3);
        tbl[15] = mk(0, 32'h0,        0, 1, 1, 7'h63, 32'hFE000E63, 1, 3);
        tbl[16] = mk(0, 32'h0,        0, 1, 1, 7'h6F, 32'h0040006F, 1, 2);
        tbl[17] = mk(0, 32'h0,        0, 1, 1, 7'h67, 32'h00008067, 1, 1);
        tbl[18] = mk(0, 32'h0,        0, 1, 0, 7'h13, 32'h0,        1, 0);
        // Build count=3, flush with in_valid high, then push 0x37
        tbl[19] = mk(1, 32'h00000101, 0, 0, 0, 7'h13, 32'h0,        1, 0);
        tbl[20] = mk(1, 32'h00000202, 0, 0, 1, 7'h01, 32'h00000101, 1, 1);
        tbl[21] = mk(1, 32'h00000303, 0, 0, 1, 7'h01, 32'h00000101, 1, 2);
        tbl[22] = mk(1, 32'h00000404, 1, 1, 0, 7'h13, 32'h0,        0, 3);
        tbl[23] = mk(1, 32'hFFFFFF37, 0, 0, 0, 7'h13, 32'h0,        1, 0);
        tbl[24] = mk(0, 32'h0,        0, 0, 1, 7'h37, 32'hFFFFFF37, 1, 1);
        tbl[25] = mk(0, 32'h0,        0, 1, 1, 7'h37, 32'hFFFFFF37, 1, 1);
        tbl[26] = mk(0, 32'h0,        0, 0, 0, 7'h13, 32'h0,        1, 0);

        drive(0, 32'h0, 0, 0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_all("reset", 0, 7'h13, 32'h0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].iv, tbl[i].instr, tbl[i].fl, tbl[i].dr);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].e_dv, tbl[i].e_op, tbl[i].e_instr,
                    tbl[i].e_ir, tbl[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // Steady push and pop at count=1 for 16 instructions
        drive(1, stream_instr(0), 0, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            drive(k < 15, stream_instr(k + 1), 0, 1);
            @(negedge clk);
            chk_all($sformatf("stream%0d", k), 1, stream_instr(k) & 32'h7F, stream_instr(k), 1, 1);
            @(posedge clk);
            #1;
        end
        drive(0, 32'h0, 0, 0);
        @(negedge clk);
        chk_all("stream_end", 0, 7'h13, 32'h0, 1, 0);

        // Asynchronous reset with two entries buffered
        @(posedge clk);
        #1 drive(1, 32'h00000077, 0, 0);
        @(posedge clk);
        #1 drive(1, 32'h00000078, 0, 0);
        @(posedge clk);
        #1 drive(0, 32'h0, 0, 0);
        @(negedge clk);
        chk_all("pre_rst", 1, 7'h77, 32'h00000077, 1, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 0, 7'h13, 32'h0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all("post_rst", 0, 7'h13, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
